// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch port and the data port; data has priority.
// Optional ARB_FAIR_EN: bounds how many data grants in a row may starve a waiting fetch.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              stall_if,
    output logic              stall_d,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state_reg, state_next;
    logic [TW-1:0]     timer_reg;
    logic              owner_reg;       // 1 = data port owns the current access
    logic              grant_d, grant_if;
    logic              timeout_hit, finish;
    logic [DATA_W-1:0] resp_data;

    logic [DATA_W-1:0] if_rdata_reg, d_rdata_reg, mem_wdata_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              if_ack_reg, d_ack_reg, mem_en_reg, mem_we_reg, err_reg;

`ifdef ARB_FAIR_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_reg;
    logic          fetch_starved;
    assign fetch_starved = if_req && (starve_reg == SW'(STARVE_MAX));
`endif

    assign timeout_hit = (timer_reg == TW'(TIMEOUT - 1));
    assign finish      = (state_reg == S_WAIT) && (mem_valid || timeout_hit);
    // A completion that races the timeout still wins and delivers real data.
    assign resp_data   = mem_valid ? mem_rdata : DATA_W'(32'hDEADBEEF);

    always_comb begin
        state_next = state_reg;
        grant_d    = 1'b0;
        grant_if   = 1'b0;
        case (state_reg)
            S_IDLE: begin
`ifdef ARB_FAIR_EN
                if (fetch_starved)  grant_if = 1'b1;
                else if (d_req)     grant_d  = 1'b1;
                else if (if_req)    grant_if = 1'b1;
`else
                if (d_req)          grant_d  = 1'b1;
                else if (if_req)    grant_if = 1'b1;
`endif
                if (grant_d || grant_if) state_next = S_ISSUE;
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (mem_valid || timeout_hit) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_reg     <= '0;
            owner_reg     <= 1'b0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
            if_ack_reg    <= 1'b0;
            d_ack_reg     <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            mem_en_reg <= 1'b0;
            if_ack_reg <= 1'b0;
            d_ack_reg  <= 1'b0;

            if (grant_d || grant_if) begin
                owner_reg     <= grant_d;
                mem_en_reg    <= 1'b1;
                mem_we_reg    <= grant_d & d_we;
                mem_addr_reg  <= grant_d ? d_addr : if_addr;
                mem_wdata_reg <= grant_d ? d_wdata : '0;
            end

            if (state_reg == S_ISSUE)
                timer_reg <= '0;
            else if ((state_reg == S_WAIT) && !mem_valid && !timeout_hit)
                timer_reg <= timer_reg + TW'(1);

            if (finish) begin
                if (!mem_valid) err_reg <= 1'b1;
                if (owner_reg) begin
                    d_ack_reg <= 1'b1;
                    if (!mem_we_reg) d_rdata_reg <= resp_data;
                end else begin
                    if_ack_reg   <= 1'b1;
                    if_rdata_reg <= resp_data;
                end
            end
        end
    end

`ifdef ARB_FAIR_EN
    // Counts data grants made while a fetch is waiting; any fetch grant resets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_reg <= '0;
        else if (grant_if)
            starve_reg <= '0;
        else if (grant_d && if_req && (starve_reg != SW'(STARVE_MAX)))
            starve_reg <= starve_reg + SW'(1);
    end
`endif

    assign if_rdata  = if_rdata_reg;
    assign if_ack    = if_ack_reg;
    assign d_rdata   = d_rdata_reg;
    assign d_ack     = d_ack_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign err       = err_reg;
    assign stall_if  = if_req & ~if_ack_reg;
    assign stall_d   = d_req & ~d_ack_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single accesses plus hand-written
// sequences for arbitration, starvation, timeout, dropped requests and mid-access reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, mem_valid;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ack, d_ack, mem_en, mem_we, stall_if, stall_d, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .stall_if(stall_if), .stall_d(stall_d), .err(err)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;     // cycles after mem_en until mem_valid
        logic [31:0] mrd;
        int          exp_lat;   // edges from request to ack
        logic [31:0] exp_if;
        logic [31:0] exp_d;
    } vec_t;

    typedef struct {
        int          en_wait;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        en_next;
        logic [31:0] addr_w;
        int          ack_wait;
        logic        ifack;
        logic        dack;
        logic [31:0] ifr;
        logic [31:0] dr;
    } obs_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plays the memory for one access; delay==0 means the memory never answers.
    task automatic serve(input int delay, input logic [31:0] mrd, input logic scramble,
                         input logic drop, output obs_t o);
        o = '{default: 0};
        while (mem_en !== 1'b1 && o.en_wait < 20) begin
            tick();
            o.en_wait++;
        end
        chk("mem_en_seen", {31'd0, mem_en}, 32'd1);
        o.we    = mem_we;
        o.addr  = mem_addr;
        o.wdata = mem_wdata;
        if (scramble) begin
            if_addr = ~if_addr;
            d_addr  = ~d_addr;
            d_wdata = ~d_wdata;
            d_we    = ~d_we;
        end
        while (o.ack_wait < 40) begin
            tick();
            o.ack_wait++;
            mem_valid = 1'b0;
            if (o.ack_wait == 1) begin
                o.en_next = mem_en;
                o.addr_w  = mem_addr;
                if (drop) begin
                    d_req  = 1'b0;
                    if_req = 1'b0;
                end
            end
            if (if_ack || d_ack) break;
            if (o.ack_wait == delay) begin
                mem_valid = 1'b1;
                mem_rdata = mrd;
            end
        end
        o.ifack = if_ack;
        o.dack  = d_ack;
        o.ifr   = if_rdata;
        o.dr    = d_rdata;
        $display("access: we=%0b addr=%h ack_if=%0b ack_d=%0b if_rdata=%h d_rdata=%h after %0d+%0d cycles",
                 o.we, o.addr, o.ifack, o.dack, o.ifr, o.dr, o.en_wait, o.ack_wait);
    endtask

    vec_t vecs[6];
    obs_t o;
    logic seen;
    logic exp_if_grant[6];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 1, 32'h2002_000A, 3, 32'h2002_000A, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 2, 32'h1111_2222, 4, 32'h2002_000A, 32'h1111_2222};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 1, 32'h5555_5555, 3, 32'h2002_000A, 32'h1111_2222};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0, 3, 32'h0BAD_C0DE, 5, 32'h0BAD_C0DE, 32'h1111_2222};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 1, 32'hFFFF_FFFF, 3, 32'h0BAD_C0DE, 32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1, 32'h0000_0000, 3, 32'h0BAD_C0DE, 32'h0000_0000};
`ifdef ARB_FAIR_EN
        exp_if_grant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        exp_if_grant = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_valid = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_ctrl", {25'd0, if_ack, d_ack, mem_en, mem_we, err, stall_if, stall_d}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single accesses from the table
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_d) begin
                d_req = 1'b1; d_we = vecs[i].we; d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
            end else begin
                if_req = 1'b1; if_addr = vecs[i].addr;
            end
            #1;
            chk("stall_pending", {31'd0, vecs[i].is_d ? stall_d : stall_if}, 32'd1);
            serve(vecs[i].delay, vecs[i].mrd, 1'b1, 1'b0, o);
            chk("latency", o.en_wait + o.ack_wait, vecs[i].exp_lat);
            chk("mem_we", {31'd0, o.we}, {31'd0, vecs[i].is_d & vecs[i].we});
            chk("mem_addr", o.addr, vecs[i].addr);
            if (vecs[i].we) chk("mem_wdata", o.wdata, vecs[i].wdata);
            chk("mem_en_one_cycle", {31'd0, o.en_next}, 32'd0);
            chk("mem_addr_held", o.addr_w, vecs[i].addr);
            chk("ack_if", {31'd0, o.ifack}, {31'd0, ~vecs[i].is_d});
            chk("ack_d", {31'd0, o.dack}, {31'd0, vecs[i].is_d});
            chk("if_rdata", o.ifr, vecs[i].exp_if);
            chk("d_rdata", o.dr, vecs[i].exp_d);
            chk("stall_at_ack", {31'd0, vecs[i].is_d ? stall_d : stall_if}, 32'd0);
            d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
            tick();
            chk("ack_pulse", {30'd0, if_ack, d_ack}, 32'd0);
            tick();
        end

        // Simultaneous requests: data store goes first, fetch after one idle cycle
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234;
        if_req = 1'b1; if_addr = 32'h300;
        serve(1, 32'h0, 1'b0, 1'b0, o);
        chk("sim_first_we", {31'd0, o.we}, 32'd1);
        chk("sim_first_addr", o.addr, 32'h80);
        chk("sim_first_wdata", o.wdata, 32'h1234);
        chk("sim_first_ack", {30'd0, o.ifack, o.dack}, 32'd1);
        chk("sim_stall_if", {31'd0, stall_if}, 32'd1);
        d_req = 1'b0; d_we = 1'b0;
        serve(1, 32'h7777_8888, 1'b0, 1'b0, o);
        chk("sim_second_addr", o.addr, 32'h300);
        chk("sim_second_we", {31'd0, o.we}, 32'd0);
        chk("sim_second_gap", o.en_wait, 32'd2);
        chk("sim_second_ack", {30'd0, o.ifack, o.dack}, 32'd2);
        chk("sim_second_rdata", o.ifr, 32'h7777_8888);
        if_req = 1'b0;
        tick();

        // Continuous data traffic with a waiting fetch
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        if_req = 1'b1; if_addr = 32'h500;
        for (int i = 0; i < 6; i++) begin
            serve(1, 32'h100 + i, 1'b0, 1'b0, o);
            chk("starve_grant", o.addr, exp_if_grant[i] ? 32'h500 : 32'h400);
            if (o.ifack) if_req = 1'b0;
        end
`ifndef ARB_FAIR_EN
        chk("starve_stall_if", {31'd0, stall_if}, 32'd1);
        d_req = 1'b0;
        serve(1, 32'h600D_F00D, 1'b0, 1'b0, o);
        chk("starve_late_fetch", o.addr, 32'h500);
        chk("starve_late_ack", {31'd0, o.ifack}, 32'd1);
        if_req = 1'b0;
`endif
        d_req = 1'b0;
        tick();

        // Request dropped during WAIT, then a spurious mem_valid in IDLE
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        serve(3, 32'hABCD_0123, 1'b0, 1'b1, o);
        chk("drop_ack", {31'd0, o.dack}, 32'd1);
        chk("drop_rdata", o.dr, 32'hABCD_0123);
        tick();
        chk("drop_ack_pulse", {31'd0, d_ack}, 32'd0);
        mem_valid = 1'b1; mem_rdata = 32'hFFFF_0000;
        tick();
        mem_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = seen | if_ack | d_ack | mem_en;
            tick();
        end
        chk("spurious_valid_quiet", {31'd0, seen}, 32'd0);
        chk("spurious_rdata_kept", d_rdata, 32'hABCD_0123);

        // Memory never answers: timeout with error flag
        chk("err_before_timeout", {31'd0, err}, 32'd0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        serve(0, 32'h0, 1'b0, 1'b0, o);
        chk("timeout_wait_cycles", o.ack_wait, 32'd17);
        chk("timeout_ack", {31'd0, o.dack}, 32'd1);
        chk("timeout_rdata", o.dr, 32'hDEAD_BEEF);
        chk("timeout_err", {31'd0, err}, 32'd1);
        d_req = 1'b0;
        repeat (3) tick();
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        tick();
        chk("err_sticky", {31'd0, err}, 32'd1);
        chk("late_valid_no_ack", {31'd0, d_ack}, 32'd0);

        // Reset in the middle of WAIT drops the access
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wdata = 32'h9999_9999;
        for (int i = 0; i < 10 && mem_en !== 1'b1; i++) tick();
        chk("midrst_issue", {31'd0, mem_en}, 32'd1);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        d_req = 1'b0;
        #1;
        chk("midrst_ctrl", {25'd0, if_ack, d_ack, mem_en, mem_we, err, stall_if, stall_d}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_mem_wdata", mem_wdata, 32'd0);
        chk("midrst_d_rdata", d_rdata, 32'd0);
        chk("midrst_if_rdata", if_rdata, 32'd0);
        tick();
        rst_n = 1'b1;
        mem_valid = 1'b1; mem_rdata = 32'h1212_1212;
        tick();
        mem_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | d_ack | if_ack | mem_en;
            tick();
        end
        chk("midrst_no_ack", {31'd0, seen}, 32'd0);
        chk("midrst_rdata_zero", d_rdata, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
